// File: rtl/inst_fetch.sv
// Instruction fetch: assembles 32-bit words from a byte-wide arbitrated memory port and hands
// each one to IF/ID for a single cycle. Define ICACHE_EN to add a direct-mapped word cache.
module inst_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          ICACHE_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        mem_gnt_i,
    input  logic [7:0]  mem_din_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);
    typedef enum logic {FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  tx_q, tx_d;
    logic [1:0]  rx_q, rx_d;
    logic        pend_q, pend_d;
    logic [31:0] word_q, word_d;
    logic [31:0] pc_out_d, inst_out_d;
    logic        req_c;
    logic        complete;
    logic        hit;
    logic [31:0] hit_word;
    logic [31:0] full_word;

    if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
        $error("ICACHE_LINES must be a power of two >= 2");
    end

    // The fourth byte arrives on mem_din_i in the same cycle the word completes.
    assign complete  = (state_q == FETCH) && pend_q && (rx_q == 2'd3);
    assign full_word = {word_q[31:8], mem_din_i};

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ICACHE_LINES-1:0] valid_q;
    logic [TAG_W-1:0]        tag_q  [ICACHE_LINES];
    logic [31:0]             data_q [ICACHE_LINES];
    logic [IDX_W-1:0]        idx;

    assign idx      = pc_q[IDX_W+1:2];
    assign hit      = (state_q == FETCH) && (tx_q == 3'd0) && !pend_q && valid_q[idx]
                      && (tag_q[idx] == pc_q[31:IDX_W+2]);
    assign hit_word = data_q[idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          valid_q      <= '0;
        else if (complete) valid_q[idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (complete) begin
            tag_q[idx]  <= pc_q[31:IDX_W+2];
            data_q[idx] <= full_word;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_word = '0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        pend_d     = 1'b0;
        word_d     = word_q;
        pc_out_d   = '0;
        inst_out_d = '0;
        req_c      = (state_q == FETCH) && (tx_q < 3'd4) && !hit;
        if (req_c && mem_gnt_i) begin
            tx_d   = tx_q + 3'd1;
            pend_d = 1'b1;
        end
        if (state_q == FETCH) begin
            if (hit && !stall_i) begin
                pc_out_d   = pc_q;
                inst_out_d = hit_word;
                pc_d       = pc_q + 32'd4;
            end else if (complete) begin
                word_d = full_word;
                tx_d   = 3'd0;
                rx_d   = 2'd0;
                if (stall_i) begin
                    state_d = HOLD;
                end else begin
                    pc_out_d   = pc_q;
                    inst_out_d = full_word;
                    pc_d       = pc_q + 32'd4;
                end
            end else if (pend_q) begin
                case (rx_q)
                    2'd0:    word_d[31:24] = mem_din_i;
                    2'd1:    word_d[23:16] = mem_din_i;
                    default: word_d[15:8]  = mem_din_i;
                endcase
                rx_d = rx_q + 2'd1;
            end
        end else if (!stall_i) begin
            pc_out_d   = pc_q;
            inst_out_d = word_q;
            pc_d       = pc_q + 32'd4;
            state_d    = FETCH;
        end
        // A redirect discards all in-flight work, including a word completing this cycle.
        if (branch_i) begin
            pc_d       = branch_target_i;
            tx_d       = 3'd0;
            rx_d       = 2'd0;
            pend_d     = 1'b0;
            state_d    = FETCH;
            pc_out_d   = '0;
            inst_out_d = '0;
        end
    end

    assign mem_req_o  = req_c & rst;
    assign mem_addr_o = mem_req_o ? (pc_q + {29'd0, tx_q}) : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            tx_q    <= 3'd0;
            rx_q    <= 2'd0;
            pend_q  <= 1'b0;
            if_pc   <= 32'd0;
            if_inst <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            pend_q  <= pend_d;
            if_pc   <= pc_out_d;
            if_inst <= inst_out_d;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, uncontended fetch, lost grant, branch, stall/HOLD,
// address wrap and reset mid-fetch; cache replay when ICACHE_EN is defined.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic        gnt;
    logic [7:0]  din;
    logic        req;
    logic [31:0] addr;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    logic [7:0] mem [512];
    int total = 0;
    int bad   = 0;

    inst_fetch #(.RESET_PC(32'h0), .ICACHE_LINES(16)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .branch_i(branch),
        .branch_target_i(target), .mem_gnt_i(gnt), .mem_din_i(din),
        .mem_req_o(req), .mem_addr_o(addr), .if_pc(if_pc), .if_inst(if_inst)
    );

    always #5 clk = ~clk;

    // One-cycle read latency; ungranted cycles return a poison byte.
    always @(posedge clk) begin
        din <= (req && gnt) ? mem[addr[8:0]] : 8'hEE;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Leaves the bench in the middle of fetch cycle 0.
    task automatic start();
        rst = 1'b0; stall = 1'b0; branch = 1'b0; gnt = 1'b1; target = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[0] = 8'h13;
        mem[4] = 8'hA1; mem[5] = 8'hB2; mem[6] = 8'hC3; mem[7] = 8'hD4;
        mem[9'h100] = 8'hDE; mem[9'h101] = 8'hAD; mem[9'h102] = 8'hBE; mem[9'h103] = 8'hEF;
        mem[9'h1FC] = 8'h11; mem[9'h1FD] = 8'h22; mem[9'h1FE] = 8'h33; mem[9'h1FF] = 8'h44;
        rst = 1'b0; stall = 1'b0; branch = 1'b0; gnt = 1'b1; target = 32'h0;

        // Reset values and uncontended fetch
        @(negedge clk);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        rst = 1'b1;
        #1;
        chk("t1_req_c0", {31'd0, req}, 32'd1);
        chk("t1_addr_c0", addr, 32'd0);
        for (int k = 1; k < 4; k++) begin
            step();
            chk($sformatf("t1_addr_c%0d", k), addr, k);
        end
        step();
        chk("t1_req_c4", {31'd0, req}, 32'd0);
        chk("t1_inst_c4", if_inst, 32'd0);
        step();
        chk("t1_pc_c5", if_pc, 32'd0);
        chk("t1_inst_c5", if_inst, 32'h13000000);
        chk("t1_addr_c5", addr, 32'd4);
        step();
        chk("t1_inst_c6", if_inst, 32'd0);
        repeat (4) step();
        chk("t1_pc_c10", if_pc, 32'd4);
        chk("t1_inst_c10", if_inst, 32'hA1B2C3D4);
        chk("t1_addr_c10", addr, 32'd8);

        // Grant lost in cycles 1-2
        start();
        step(); gnt = 1'b0;
        chk("t2_addr_c1", addr, 32'd1);
        step();
        chk("t2_addr_c2", addr, 32'd1);
        step(); gnt = 1'b1;
        chk("t2_addr_c3", addr, 32'd1);
        step();
        chk("t2_addr_c4", addr, 32'd2);
        step();
        chk("t2_addr_c5", addr, 32'd3);
        step();
        chk("t2_inst_c6", if_inst, 32'd0);
        step();
        chk("t2_pc_c7", if_pc, 32'd0);
        chk("t2_inst_c7", if_inst, 32'h13000000);

        // Branch to 0x100 in cycle 2
        start();
        step(); step();
        chk("t3_addr_c2", addr, 32'd2);
        branch = 1'b1; target = 32'h100;
        step(); branch = 1'b0;
        chk("t3_addr_c3", addr, 32'h100);
        chk("t3_req_c3", {31'd0, req}, 32'd1);
        for (int c = 3; c < 8; c++) begin
            if (c > 3) step();
            chk($sformatf("t3_inst_c%0d", c), if_inst, 32'd0);
        end
        step();
        chk("t3_pc_c8", if_pc, 32'h100);
        chk("t3_inst_c8", if_inst, 32'hDEADBEEF);

        // Stall cycles 3-8
        start();
        step(); step(); step(); stall = 1'b1;
        step();
        for (int c = 5; c < 9; c++) begin
            step();
            chk($sformatf("t4_req_c%0d", c), {31'd0, req}, 32'd0);
            chk($sformatf("t4_inst_c%0d", c), if_inst, 32'd0);
        end
        step(); stall = 1'b0;
        chk("t4_inst_c9", if_inst, 32'd0);
        step();
        chk("t4_pc_c10", if_pc, 32'd0);
        chk("t4_inst_c10", if_inst, 32'h13000000);
        chk("t4_addr_c10", addr, 32'd4);
        step();
        chk("t4_inst_c11", if_inst, 32'd0);

        // Address wrap through 0xFFFFFFFC
        start();
        branch = 1'b1; target = 32'hFFFFFFFC;
        step(); branch = 1'b0;
        chk("t5_addr_c1", addr, 32'hFFFFFFFC);
        step(); step(); step();
        chk("t5_addr_c4", addr, 32'hFFFFFFFF);
        step();
        chk("t5_req_c5", {31'd0, req}, 32'd0);
        step();
        chk("t5_pc_c6", if_pc, 32'hFFFFFFFC);
        chk("t5_inst_c6", if_inst, 32'h11223344);
        chk("t5_addr_c6", addr, 32'd0);

        // Reset asserted mid-fetch
        start();
        step(); step();
        rst = 1'b0;
        #1;
        chk("t6_req_rst", {31'd0, req}, 32'd0);
        chk("t6_addr_rst", addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_addr_c0", addr, 32'd0);
        chk("t6_req_c0", {31'd0, req}, 32'd1);
        repeat (5) step();
        chk("t6_pc_c5", if_pc, 32'd0);
        chk("t6_inst_c5", if_inst, 32'h13000000);

`ifdef ICACHE_EN
        // Second pass over 0x0/0x4 is served from the cache
        repeat (5) step();
        chk("t7_pc_c10", if_pc, 32'd4);
        branch = 1'b1; target = 32'h0;
        step(); branch = 1'b0;
        chk("t7_req_c11", {31'd0, req}, 32'd0);
        step();
        chk("t7_pc_c12", if_pc, 32'd0);
        chk("t7_inst_c12", if_inst, 32'h13000000);
        chk("t7_req_c12", {31'd0, req}, 32'd0);
        step();
        chk("t7_pc_c13", if_pc, 32'd4);
        chk("t7_inst_c13", if_inst, 32'hA1B2C3D4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
